// File: rtl/receive_data_fsm.sv
`default_nettype none
// ============================================================================
// Module   : receive_data_fsm
// Purpose  : UART command decoder. Loads 32-bit instruction words, MSB byte
//            first, into instruction memory. Also starts continuous run or a
//            single step, then hands off to the debug-send FSM.
// Options  : RX_TIMEOUT_EN - abort a stalled load after TIMEOUT_CYCLES idle
//            cycles and pulse o_error.
// Revision : 1.0 - initial release
// ============================================================================
module receive_data_fsm #(
    parameter int UART_BITS        = 8,
    parameter int INSTRUCTION_BITS = 32,
    parameter int INST_ADDRS_BITS  = 8,
    parameter int TIMEOUT_CYCLES   = 1000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_rx_done,
    input  logic [UART_BITS-1:0]        i_rx_data,
    input  logic                        i_halt,
    input  logic                        i_send_done,
    output logic                        o_inst_we,
    output logic [INST_ADDRS_BITS-1:0]  o_inst_addr,
    output logic [INSTRUCTION_BITS-1:0] o_inst_data,
    output logic                        o_datapath_rst,
    output logic                        o_run,
    output logic                        o_step,
    output logic                        o_send_start,
    output logic                        o_error
);

    localparam int c_BYTES_PER_INST = INSTRUCTION_BITS / UART_BITS;
    localparam int c_BCNT_W         = (c_BYTES_PER_INST > 1) ? $clog2(c_BYTES_PER_INST) : 1;
    // One extra bit so a count byte of zero can stand for 2^UART_BITS words
    localparam int c_REM_W          = UART_BITS + 1;

    localparam logic [UART_BITS-1:0] c_CMD_LOAD = UART_BITS'(1);
    localparam logic [UART_BITS-1:0] c_CMD_RUN  = UART_BITS'(2);
    localparam logic [UART_BITS-1:0] c_CMD_STEP = UART_BITS'(3);
    localparam logic [c_REM_W-1:0]   c_REM_FULL = c_REM_W'(1) << UART_BITS;
    localparam logic [c_BCNT_W-1:0]  c_BCNT_LAST = c_BCNT_W'(c_BYTES_PER_INST - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_COUNT = 3'd1,
        LOAD_BYTE  = 3'd2,
        WRITE_INST = 3'd3,
        RUN        = 3'd4,
        STEP       = 3'd5,
        SEND_START = 3'd6,
        SEND_WAIT  = 3'd7
    } state_t;

    state_t                      r_state;
    logic                        r_loaded;
    logic [INST_ADDRS_BITS-1:0]  r_addr;
    logic [c_REM_W-1:0]          r_remaining;
    logic [c_BCNT_W-1:0]         r_byte_cnt;
    logic [INSTRUCTION_BITS-1:0] r_word;

    logic                        r_inst_we;
    logic [INST_ADDRS_BITS-1:0]  r_inst_addr;
    logic [INSTRUCTION_BITS-1:0] r_inst_data;
    logic                        r_datapath_rst;
    logic                        r_run;
    logic                        r_step;
    logic                        r_send_start;
    logic                        r_error;

    logic                        w_timeout;
    logic [INSTRUCTION_BITS-1:0] w_word_next;

    // New byte enters at the bottom, so the first byte ends up as the MSB
    assign w_word_next = {r_word[INSTRUCTION_BITS-UART_BITS-1:0], i_rx_data};

`ifdef RX_TIMEOUT_EN
    localparam int                   c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0]    c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_timeout_cnt;
    logic              w_in_load;

    assign w_in_load = (r_state == LOAD_COUNT) || (r_state == LOAD_BYTE);
    // Fires on the cycle whose edge completes TIMEOUT_CYCLES byte-free cycles
    assign w_timeout = w_in_load && !i_rx_done && (r_timeout_cnt == c_TO_LAST);

    // Counts idle cycles while waiting for load bytes; any byte restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout_cnt <= '0;
        end else if (w_in_load && !i_rx_done && !w_timeout) begin
            r_timeout_cnt <= r_timeout_cnt + c_TO_W'(1);
        end else begin
            r_timeout_cnt <= '0;
        end
    end
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
`endif

    // Main controller: state, load bookkeeping and registered Moore outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_loaded       <= 1'b0;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_byte_cnt     <= '0;
            r_word         <= '0;
            r_inst_we      <= 1'b0;
            r_inst_addr    <= '0;
            r_inst_data    <= '0;
            r_datapath_rst <= 1'b0;
            r_run          <= 1'b0;
            r_step         <= 1'b0;
            r_send_start   <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            // Outputs describe the state being entered; anything not set is 0
            r_inst_we      <= 1'b0;
            r_inst_addr    <= '0;
            r_inst_data    <= '0;
            r_datapath_rst <= 1'b0;
            r_run          <= 1'b0;
            r_step         <= 1'b0;
            r_send_start   <= 1'b0;
            r_error        <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (i_rx_done) begin
                        if (i_rx_data == c_CMD_LOAD) begin
                            r_state        <= LOAD_COUNT;
                            r_datapath_rst <= 1'b1;
                        end else if ((i_rx_data == c_CMD_RUN) && r_loaded) begin
                            r_state <= RUN;
                            r_run   <= 1'b1;
                        end else if ((i_rx_data == c_CMD_STEP) && r_loaded) begin
                            r_state <= STEP;
                            r_step  <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end

                LOAD_COUNT: begin
                    if (w_timeout) begin
                        r_state  <= IDLE;
                        r_loaded <= 1'b0;
                        r_error  <= 1'b1;
                    end else begin
                        r_datapath_rst <= 1'b1;
                        if (i_rx_done) begin
                            r_remaining <= (i_rx_data == '0) ? c_REM_FULL : {1'b0, i_rx_data};
                            r_addr      <= '0;
                            r_byte_cnt  <= '0;
                            r_loaded    <= 1'b0;
                            r_state     <= LOAD_BYTE;
                        end
                    end
                end

                LOAD_BYTE: begin
                    if (w_timeout) begin
                        r_state  <= IDLE;
                        r_loaded <= 1'b0;
                        r_error  <= 1'b1;
                    end else begin
                        r_datapath_rst <= 1'b1;
                        if (i_rx_done) begin
                            r_word <= w_word_next;
                            if (r_byte_cnt == c_BCNT_LAST) begin
                                r_byte_cnt  <= '0;
                                r_inst_we   <= 1'b1;
                                r_inst_addr <= r_addr;
                                r_inst_data <= w_word_next;
                                r_state     <= WRITE_INST;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + c_BCNT_W'(1);
                            end
                        end
                    end
                end

                WRITE_INST: begin
                    r_addr      <= r_addr + INST_ADDRS_BITS'(1);
                    r_remaining <= r_remaining - c_REM_W'(1);
                    if (r_remaining == c_REM_W'(1)) begin
                        r_loaded <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_byte_cnt     <= '0;
                        r_datapath_rst <= 1'b1;
                        r_state        <= LOAD_BYTE;
                    end
                end

                RUN: begin
                    if (i_halt) begin
                        r_send_start <= 1'b1;
                        r_state      <= SEND_START;
                    end else begin
                        r_run <= 1'b1;
                    end
                end

                STEP: begin
                    r_send_start <= 1'b1;
                    r_state      <= SEND_START;
                end

                SEND_START: begin
                    r_state <= SEND_WAIT;
                end

                SEND_WAIT: begin
                    if (i_send_done) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_inst_we      = r_inst_we;
    assign o_inst_addr    = r_inst_addr;
    assign o_inst_data    = r_inst_data;
    assign o_datapath_rst = r_datapath_rst;
    assign o_run          = r_run;
    assign o_step         = r_step;
    assign o_send_start   = r_send_start;
    assign o_error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_receive_data_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_receive_data_fsm
// Purpose  : Randomized self-checking bench for receive_data_fsm against a
//            command/load-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_receive_data_fsm;

    logic        clk;
    logic        rst;
    logic        i_rx_done;
    logic [7:0]  i_rx_data;
    logic        i_halt;
    logic        i_send_done;
    logic        o_inst_we;
    logic [7:0]  o_inst_addr;
    logic [31:0] o_inst_data;
    logic        o_datapath_rst;
    logic        o_run;
    logic        o_step;
    logic        o_send_start;
    logic        o_error;

    int          vectors     = 0;
    int          miscompares = 0;
    bit          model_loaded = 1'b0;
    logic [31:0] load_q[$];

    receive_data_fsm #(
        .UART_BITS        (8),
        .INSTRUCTION_BITS (32),
        .INST_ADDRS_BITS  (8),
        .TIMEOUT_CYCLES   (100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rx_done      (i_rx_done),
        .i_rx_data      (i_rx_data),
        .i_halt         (i_halt),
        .i_send_done    (i_send_done),
        .o_inst_we      (o_inst_we),
        .o_inst_addr    (o_inst_addr),
        .o_inst_data    (o_inst_data),
        .o_datapath_rst (o_datapath_rst),
        .o_run          (o_run),
        .o_step         (o_step),
        .o_send_start   (o_send_start),
        .o_error        (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which command bytes IDLE accepts
    function automatic bit model_accepts(input logic [7:0] b, input bit loaded);
        return (b == 8'h01) || (loaded && ((b == 8'h02) || (b == 8'h03)));
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_done = 1'b1;
        i_rx_data = b;
        tick();
        i_rx_done = 1'b0;
        i_rx_data = 8'($urandom);
    endtask

    task automatic pulse_send_done();
        i_send_done = 1'b1;
        tick();
        i_send_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (o_inst_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", o_inst_we); end
        vectors++; if (o_inst_addr !== 8'h00) begin miscompares++; $display("FAIL reset_addr: got %h expected 00", o_inst_addr); end
        vectors++; if (o_inst_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", o_inst_data); end
        vectors++; if ({o_datapath_rst, o_run, o_step, o_send_start, o_error} !== 5'b0) begin
            miscompares++; $display("FAIL reset_ctrl: got %b expected 00000", {o_datapath_rst, o_run, o_step, o_send_start, o_error});
        end
        rst = 1'b0;
        model_loaded = 1'b0;
        tick();
        vectors++; if ({o_inst_we, o_datapath_rst, o_run, o_error} !== 4'b0) begin
            miscompares++; $display("FAIL post_reset_idle: got %b expected 0000", {o_inst_we, o_datapath_rst, o_run, o_error});
        end
    endtask

    task automatic test_reject_unloaded();
        logic [7:0] b;
        bit         exp_err;
        send_byte(8'h02);
        exp_err = !model_accepts(8'h02, model_loaded);
        vectors++; if (o_error !== exp_err) begin miscompares++; $display("FAIL run_unloaded_err: got %b expected %b", o_error, exp_err); end
        vectors++; if (o_run !== 1'b0) begin miscompares++; $display("FAIL run_unloaded_run: got %b expected 0", o_run); end
        tick();
        vectors++; if (o_error !== 1'b0) begin miscompares++; $display("FAIL err_one_cycle: got %b expected 0", o_error); end
        send_byte(8'h7F);
        exp_err = !model_accepts(8'h7F, model_loaded);
        vectors++; if (o_error !== exp_err) begin miscompares++; $display("FAIL bad_7f_err: got %b expected %b", o_error, exp_err); end
        vectors++; if (o_run !== 1'b0) begin miscompares++; $display("FAIL bad_7f_run: got %b expected 0", o_run); end
        tick();
        for (int i = 0; i < 6; i++) begin
            do b = 8'($urandom_range(0, 255)); while (b == 8'h01);
            send_byte(b);
            exp_err = !model_accepts(b, model_loaded);
            vectors++; if (o_error !== exp_err) begin miscompares++; $display("FAIL rand_unloaded_err byte %h: got %b expected %b", b, o_error, exp_err); end
            vectors++; if ({o_run, o_step, o_datapath_rst} !== 3'b0) begin
                miscompares++; $display("FAIL rand_unloaded_ctrl byte %h: got %b expected 000", b, {o_run, o_step, o_datapath_rst});
            end
            tick();
        end
    endtask

    task automatic test_reject_loaded();
        logic [7:0] b;
        bit         exp_err;
        for (int i = 0; i < 6; i++) begin
            do b = 8'($urandom_range(0, 255)); while (b == 8'h01 || b == 8'h02 || b == 8'h03);
            send_byte(b);
            exp_err = !model_accepts(b, model_loaded);
            vectors++; if (o_error !== exp_err) begin miscompares++; $display("FAIL rand_loaded_err byte %h: got %b expected %b", b, o_error, exp_err); end
            vectors++; if ({o_run, o_step} !== 2'b0) begin miscompares++; $display("FAIL rand_loaded_ctrl byte %h: got %b expected 00", b, {o_run, o_step}); end
            tick();
        end
    endtask

    // Idle gap inside a load: datapath stays in reset, nothing is written
    task automatic load_gap(input int max_gap);
        repeat ($urandom_range(0, max_gap)) begin
            i_rx_data = 8'($urandom);
            tick();
            vectors++; if ({o_datapath_rst, o_inst_we} !== 2'b10) begin
                miscompares++; $display("FAIL load_gap: got rst/we %b expected 10", {o_datapath_rst, o_inst_we});
            end
        end
    endtask

    // Loads the words in load_q using the given count byte
    task automatic run_load(input logic [7:0] count_byte, input int max_gap);
        int          n;
        logic [31:0] word;
        logic [7:0]  exp_addr;
        n = (count_byte == 8'h00) ? 256 : int'(count_byte);
        send_byte(8'h01);
        vectors++; if ({o_datapath_rst, o_error} !== 2'b10) begin
            miscompares++; $display("FAIL load_cmd: got rst/err %b expected 10", {o_datapath_rst, o_error});
        end
        load_gap(max_gap);
        send_byte(count_byte);
        model_loaded = 1'b0;
        vectors++; if ({o_datapath_rst, o_inst_we} !== 2'b10) begin
            miscompares++; $display("FAIL load_count: got rst/we %b expected 10", {o_datapath_rst, o_inst_we});
        end
        for (int w = 0; w < n; w++) begin
            word     = load_q[w];
            exp_addr = 8'(w);
            for (int b = 0; b < 4; b++) begin
                load_gap(max_gap);
                send_byte(word[31-8*b -: 8]);
                if (b < 3) begin
                    vectors++; if ({o_datapath_rst, o_inst_we} !== 2'b10) begin
                        miscompares++; $display("FAIL load_byte w%0d b%0d: got rst/we %b expected 10", w, b, {o_datapath_rst, o_inst_we});
                    end
                end
            end
            vectors++; if (o_inst_we !== 1'b1) begin miscompares++; $display("FAIL write_we w%0d: got %b expected 1", w, o_inst_we); end
            vectors++; if (o_inst_addr !== exp_addr) begin miscompares++; $display("FAIL write_addr w%0d: got %h expected %h", w, o_inst_addr, exp_addr); end
            vectors++; if (o_inst_data !== word) begin miscompares++; $display("FAIL write_data w%0d: got %h expected %h", w, o_inst_data, word); end
            vectors++; if (o_datapath_rst !== 1'b1) begin miscompares++; $display("FAIL write_rst w%0d: got %b expected 1", w, o_datapath_rst); end
            tick();
            vectors++; if (o_inst_we !== 1'b0) begin miscompares++; $display("FAIL write_one_cycle w%0d: got %b expected 0", w, o_inst_we); end
            vectors++; if (o_datapath_rst !== (w < n - 1)) begin
                miscompares++; $display("FAIL after_write_rst w%0d: got %b expected %b", w, o_datapath_rst, (w < n - 1));
            end
        end
        model_loaded = 1'b1;
    endtask

    task automatic test_load_fixed();
        load_q = '{32'hAABBCCDD, 32'h11223344};
        run_load(8'h02, 0);
    endtask

    task automatic test_load_random();
        int cnt;
        cnt = $urandom_range(1, 6);
        load_q.delete();
        for (int i = 0; i < cnt; i++) load_q.push_back($urandom);
        run_load(8'(cnt), 3);
    endtask

    task automatic test_run(input int n);
        int  run_cycles;
        bit  exp_acc;
        exp_acc = model_accepts(8'h02, model_loaded);
        send_byte(8'h02);
        vectors++; if (o_run !== exp_acc) begin miscompares++; $display("FAIL run_start: got %b expected %b", o_run, exp_acc); end
        run_cycles = 0;
        for (int i = 1; i <= n; i++) begin
            if (o_run === 1'b1) run_cycles++;
            if (i == n) i_halt = 1'b1;
            tick();
        end
        i_halt = 1'b0;
        vectors++; if (run_cycles !== n) begin miscompares++; $display("FAIL run_length: got %0d expected %0d", run_cycles, n); end
        vectors++; if ({o_run, o_send_start} !== 2'b01) begin
            miscompares++; $display("FAIL run_halt: got run/send %b expected 01", {o_run, o_send_start});
        end
        tick();
        vectors++; if (o_send_start !== 1'b0) begin miscompares++; $display("FAIL run_send_pulse: got %b expected 0", o_send_start); end
        send_byte(8'h02);
        vectors++; if ({o_run, o_error} !== 2'b00) begin
            miscompares++; $display("FAIL wait_ignore_run: got run/err %b expected 00", {o_run, o_error});
        end
        repeat ($urandom_range(0, 5)) tick();
        pulse_send_done();
    endtask

    task automatic test_step();
        send_byte(8'h03);
        vectors++; if ({o_step, o_send_start} !== 2'b10) begin
            miscompares++; $display("FAIL step_pulse: got step/send %b expected 10", {o_step, o_send_start});
        end
        tick();
        vectors++; if ({o_step, o_send_start} !== 2'b01) begin
            miscompares++; $display("FAIL step_send: got step/send %b expected 01", {o_step, o_send_start});
        end
        tick();
        vectors++; if (o_send_start !== 1'b0) begin miscompares++; $display("FAIL step_send_one: got %b expected 0", o_send_start); end
        send_byte(8'h03);
        vectors++; if ({o_step, o_error} !== 2'b00) begin
            miscompares++; $display("FAIL wait_ignore_step: got step/err %b expected 00", {o_step, o_error});
        end
        repeat ($urandom_range(1, 4)) tick();
        pulse_send_done();
        send_byte(8'h03);
        vectors++; if (o_step !== 1'b1) begin miscompares++; $display("FAIL step_after_done: got %b expected 1", o_step); end
        tick();
        tick();
        pulse_send_done();
    endtask

    task automatic test_load_full();
        load_q.delete();
        for (int i = 0; i < 256; i++) load_q.push_back($urandom);
        run_load(8'h00, 1);
        send_byte(8'h03);
        vectors++; if (o_step !== model_loaded) begin miscompares++; $display("FAIL full_load_loaded: got %b expected %b", o_step, model_loaded); end
        tick();
        tick();
        pulse_send_done();
    endtask

    task automatic test_reset_midload();
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'hAB);
        send_byte(8'hCD);
        vectors++; if (o_datapath_rst !== 1'b1) begin miscompares++; $display("FAIL midload_rst_before: got %b expected 1", o_datapath_rst); end
        rst = 1'b1;
        #1;
        vectors++; if ({o_inst_we, o_datapath_rst, o_run, o_step, o_send_start, o_error} !== 6'b0) begin
            miscompares++; $display("FAIL async_reset: got %b expected 000000", {o_inst_we, o_datapath_rst, o_run, o_step, o_send_start, o_error});
        end
        model_loaded = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (o_inst_we !== 1'b0) begin miscompares++; $display("FAIL midload_no_write: got %b expected 0", o_inst_we); end
        end
        send_byte(8'h02);
        vectors++; if (o_error !== !model_accepts(8'h02, model_loaded)) begin
            miscompares++; $display("FAIL midload_run_reject: got %b expected %b", o_error, !model_accepts(8'h02, model_loaded));
        end
        vectors++; if (o_run !== 1'b0) begin miscompares++; $display("FAIL midload_run: got %b expected 0", o_run); end
        tick();
    endtask

    task automatic test_stall();
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
`ifdef RX_TIMEOUT_EN
        for (int i = 1; i < 100; i++) begin
            tick();
            vectors++; if ({o_error, o_datapath_rst} !== 2'b01) begin
                miscompares++; $display("FAIL stall_wait c%0d: got err/rst %b expected 01", i, {o_error, o_datapath_rst});
            end
        end
        tick();
        vectors++; if ({o_error, o_datapath_rst} !== 2'b10) begin
            miscompares++; $display("FAIL timeout_err: got err/rst %b expected 10", {o_error, o_datapath_rst});
        end
        model_loaded = 1'b0;
        tick();
        vectors++; if (o_error !== 1'b0) begin miscompares++; $display("FAIL timeout_one: got %b expected 0", o_error); end
        send_byte(8'h02);
        vectors++; if (o_error !== !model_accepts(8'h02, model_loaded)) begin
            miscompares++; $display("FAIL timeout_reject: got %b expected %b", o_error, !model_accepts(8'h02, model_loaded));
        end
        tick();
`else
        for (int i = 0; i < 150; i++) begin
            tick();
            vectors++; if ({o_error, o_datapath_rst, o_inst_we} !== 3'b010) begin
                miscompares++; $display("FAIL stall_wait c%0d: got err/rst/we %b expected 010", i, {o_error, o_datapath_rst, o_inst_we});
            end
        end
        send_byte(8'hEF);
        vectors++; if (o_inst_we !== 1'b1) begin miscompares++; $display("FAIL stall_write_we: got %b expected 1", o_inst_we); end
        vectors++; if (o_inst_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL stall_write_data: got %h expected deadbeef", o_inst_data); end
        tick();
        model_loaded = 1'b1;
        vectors++; if (o_datapath_rst !== 1'b0) begin miscompares++; $display("FAIL stall_idle: got %b expected 0", o_datapath_rst); end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        i_rx_done   = 1'b0;
        i_rx_data   = 8'h00;
        i_halt      = 1'b0;
        i_send_done = 1'b0;
        test_reset();
        test_reject_unloaded();
        test_load_fixed();
        test_run(50);
        test_run(1);
        test_run($urandom_range(2, 20));
        test_step();
        test_reject_loaded();
        test_load_random();
        test_run($urandom_range(2, 20));
        test_load_full();
        test_reset_midload();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
